// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares one FIFO write port among NUM_REQ
//   producers. A multi-beat packet (delimited by req_last) locks the grant
//   to its owner so packets are never interleaved in the FIFO. Each FIFO
//   word is tagged with the index of the requester that produced it.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   req_valid      [NUM_REQ]            requester i presents a beat
//   req_last       [NUM_REQ]            presented beat ends requester i's packet
//   req_data       [NUM_REQ*DATA_WIDTH] requester i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready      [NUM_REQ]            beat of requester i accepted this cycle
//   fifo_full      FIFO full flag
//   fifo_wr_en     FIFO write enable
//   fifo_wr_data   {source index, payload} to FIFO data_in
//   busy           a packet currently holds the lock
//   grant_id       index of the currently granted requester

// One requester's ready slice: ready only when it holds the grant and the
// beat is being accepted.
module fifo_wr_arbiter_lane #(
    parameter int IDW = 2,
    parameter int IDX = 0
) (
    input  logic           acc,
    input  logic [IDW-1:0] grant_id,
    output logic           ready
);
    assign ready = acc && (grant_id == IDW'(IDX));
endmodule

module fifo_wr_arbiter #(
    parameter int  DATA_WIDTH = 8,
    parameter int  NUM_REQ    = 4,
    localparam int IDW        = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH+IDW-1:0]     fifo_wr_data,
    output logic                          busy,
    output logic [IDW-1:0]                grant_id
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [IDW-1:0]       prio_ptr, prio_ptr_nxt;
    logic [IDW-1:0]       owner, owner_nxt;

    logic [IDW-1:0]       rr_id;
    logic                 rr_hit;
    logic [IDW:0]         rr_sum;
    logic                 grant_vld;
    logic                 acc;
    logic                 last_sel;

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_a;
    assign req_data_a = req_data;

    // Increment modulo NUM_REQ; never produces an index >= NUM_REQ even
    // when NUM_REQ is not a power of two.
    function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] x);
        return (x == IDW'(NUM_REQ - 1)) ? '0 : x + 1'b1;
    endfunction

    // Round-robin search starting at prio_ptr. The sum is one bit wider
    // than an index so prio_ptr + k (< 2*NUM_REQ) cannot overflow before
    // the modulo fold.
    always_comb begin
        rr_id  = prio_ptr;
        rr_hit = 1'b0;
        rr_sum = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_sum = {1'b0, prio_ptr} + (IDW+1)'(k);
            if (rr_sum >= (IDW+1)'(NUM_REQ))
                rr_sum = rr_sum - (IDW+1)'(NUM_REQ);
            if (!rr_hit && req_valid[rr_sum[IDW-1:0]]) begin
                rr_id  = rr_sum[IDW-1:0];
                rr_hit = 1'b1;
            end
        end
    end

    // While locked only the owner can be granted, even if it has dropped
    // valid; the lock is held until the owner's last beat is accepted.
    always_comb begin
        if (!rst_n)
            grant_id = '0;
        else if (state == LOCKED)
            grant_id = owner;
        else
            grant_id = rr_id;
    end

    assign grant_vld    = (state == LOCKED) ? req_valid[owner] : rr_hit;
    assign acc          = rst_n && grant_vld && !fifo_full;
    assign last_sel     = req_last[grant_id];
    assign fifo_wr_en   = acc;
    assign fifo_wr_data = {grant_id, req_data_a[grant_id]};
    assign busy         = rst_n && (state == LOCKED);

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        fifo_wr_arbiter_lane #(
            .IDW (IDW),
            .IDX (i)
        ) u_lane (
            .acc      (acc),
            .grant_id (grant_id),
            .ready    (req_ready[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            prio_ptr <= '0;
            owner    <= '0;
        end else begin
            state    <= state_nxt;
            prio_ptr <= prio_ptr_nxt;
            owner    <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        prio_ptr_nxt = prio_ptr;
        owner_nxt    = owner;
        if (acc) begin
            case (state)
                IDLE: begin
                    if (last_sel) begin
                        prio_ptr_nxt = inc_wrap(grant_id);
                    end else begin
                        state_nxt = LOCKED;
                        owner_nxt = grant_id;
                    end
                end
                LOCKED: begin
                    if (last_sel) begin
                        state_nxt    = IDLE;
                        prio_ptr_nxt = inc_wrap(owner);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule
